dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port, registered-read data memory between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA loader. Each port uses a valid/ready request channel with byte enables and an unthrottled response pulse. The memory has no byte mask, so the block sequences sub-word stores as read-modify-write. It sits between the requesters and the data memory instance.

Parameters:
XLEN, 32, data/address width; byte enables are XLEN/8 bits wide.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
s0_req_valid  in  1  port 0 request valid
s0_req_ready  out  1  port 0 request accepted this cycle
s0_req_addr  in  XLEN  port 0 byte address; bits [1:0] ignored
s0_req_we  in  1  port 0 1=store, 0=load
s0_req_be  in  XLEN/8  port 0 store byte enables, already lane-aligned
s0_req_wdata  in  XLEN  port 0 store data, lane-aligned
s0_rsp_valid  out  1  port 0 one-cycle completion pulse (load data or store ack)
s0_rsp_rdata  out  XLEN  port 0 load data; valid only with s0_rsp_valid
s1_*  (same eight signals)  port 1
mem_addr  out  XLEN  byte address to memory
mem_wdata  out  XLEN  write data to memory
mem_we  out  1  memory write enable
mem_rdata  in  XLEN  memory read data, valid one cycle after a read is issued
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset: state=IDLE; round-robin pointer set to favour port 0; all outputs 0. Reset mid-transaction drops the latched request with no response.
- Ready: sN_req_ready is combinational and is high only in IDLE, for the arbitration winner. Handshake = valid && ready. Requesters hold request fields stable while valid && !ready.
- Arbitration: in IDLE, if one port is valid, it wins. If both are valid, the port not granted last wins. The pointer updates on each grant.
- On accept, latch addr, we, be, wdata and the owner id.
- FSM states:
  - IDLE: on accept of a load or a partial store (be != all-ones and be != 0), go to RD. On accept of a full store or a be=0 store, go to WR.
  - RD: mem_addr=latched addr, mem_we=0. Go to RDW.
  - RDW: mem_rdata is valid.
    - Load: pulse owner rsp_valid with rsp_rdata=mem_rdata, then go to IDLE.
    - Partial store: merged[byte i] = be[i] ? wdata[byte i] : mem_rdata[byte i]. Go to WR.
  - WR: mem_addr=latched addr, mem_wdata=merged (or wdata for a full store), mem_we=1, except mem_we=0 when be=0. Pulse owner rsp_valid (store ack) in this cycle. Go to IDLE.
- Latency, counted from the accept edge at T0:
  - load response in cycle T0+2
  - full or be=0 store ack in cycle T0+1
  - partial store ack in cycle T0+3
- Throughput: one transaction in flight. A new accept is possible in the cycle after the response.
- Outside RD/WR, mem_we=0 and mem_addr/mem_wdata hold their last values.
- rsp_valid is never asserted to the non-owner. rsp_rdata is 0 when not valid.
- Load byte enables are ignored; the full word is returned.

Optional Feature:
DMEM_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins when both ports are valid; the round-robin pointer is not implemented.
- Undefined: round-robin as described above.

Test Plan:
- Reset with rst_n=0 mid-RD, then release -> all outputs 0, busy=0, no rsp_valid; the next request is accepted normally.
- Port 0 load at addr 0x10 with mem word 0xDEADBEEF -> s0_rsp_valid in cycle T0+2 with s0_rsp_rdata=0xDEADBEEF; mem_we stays 0 throughout.
- Port 1 store with be=4'b0011, wdata=0x0000CAFE to a word holding 0x12345678 -> mem_we=1 at T0+3 with mem_wdata=0x1234CAFE; s1_rsp_valid pulses in the same cycle.
- Full store with be=4'hF and wdata=0xA5A5A5A5 -> only WR is visited; mem_we=1 at T0+1; no read is issued.
- Both ports hold valid loads continuously for 4 transactions -> grants alternate 0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN defined, all grants go to port 0 while port 1 waits.
- Store with be=4'h0 -> ack at T0+1 and mem_we stays 0; memory contents are unchanged on readback.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side channel of dmem_arbiter: valid/ready request with byte enables
// and an unthrottled one-cycle response pulse.
interface dmem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_we;
  logic [XLEN/8-1:0] req_be;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port registered-read data memory; sub-word
// stores become read-modify-write. Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    s0,
  dmem_arbiter_if.slave    s1,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic             mem_we,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             busy
);
  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;

  state_t            state;
  logic              we_q;
  logic              owner_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   wdata_q;

  logic              grant0;
  logic              grant1;
  logic              idle;
  logic              accept;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [XLEN-1:0]   sel_addr;
  logic [XLEN-1:0]   sel_wdata;
  logic              rsp_fire;

  function automatic logic is_partial(input logic [BE_W-1:0] be);
    return (be != '0) && (be != '1);
  endfunction

  function automatic logic [XLEN-1:0] merge_bytes(input logic [BE_W-1:0] be,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] m;
    for (int i = 0; i < BE_W; i++)
      m[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    return m;
  endfunction

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign grant0 = s0.req_valid;
  assign grant1 = s1.req_valid && !s0.req_valid;
`else
  // last_grant = 1 means port 1 was served last, so port 0 wins a tie.
  logic last_grant;

  assign grant0 = s0.req_valid && (!s1.req_valid || last_grant);
  assign grant1 = s1.req_valid && (!s0.req_valid || !last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end
`endif

  // Ready is also held low while reset is asserted so every output reads 0.
  assign idle         = (state == IDLE) && rst_n;
  assign s0.req_ready = idle && grant0;
  assign s1.req_ready = idle && grant1;
  assign accept       = s0.req_ready || s1.req_ready;

  assign sel_we    = grant1 ? s1.req_we    : s0.req_we;
  assign sel_be    = grant1 ? s1.req_be    : s0.req_be;
  assign sel_addr  = grant1 ? s1.req_addr  : s0.req_addr;
  assign sel_wdata = grant1 ? s1.req_wdata : s0.req_wdata;

  // Request capture: data-path fields carry no reset, the FSM guards their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= sel_we;
      be_q    <= sel_be;
      wdata_q <= sel_wdata;
      owner_q <= grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (accept) begin
            mem_addr <= sel_addr;
            if (!sel_we || is_partial(sel_be)) begin
              state <= RD;
            end else begin
              state     <= WR;
              mem_wdata <= sel_wdata;
              mem_we    <= |sel_be;
            end
          end
        end
        RD: begin
          state <= RDW;
        end
        RDW: begin
          if (we_q) begin
            mem_wdata <= merge_bytes(be_q, wdata_q, mem_rdata);
            mem_we    <= 1'b1;
            state     <= WR;
          end else begin
            state <= IDLE;
          end
        end
        WR: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Load data is returned straight from the memory during RDW.
  assign rsp_fire     = ((state == RDW) && !we_q) || (state == WR);
  assign s0.rsp_valid = rsp_fire && !owner_q;
  assign s1.rsp_valid = rsp_fire && owner_q;
  assign s0.rsp_rdata = (s0.rsp_valid && !we_q) ? mem_rdata : '0;
  assign s1.rsp_rdata = (s1.rsp_valid && !we_q) ? mem_rdata : '0;
  assign busy         = (state != IDLE);

endmodule
